// File: rtl/md_seq.sv
// Multiply/divide sequencer for the EX stage: latches operands, runs the pipelined
// multiplier or iterative divider, and issues a one-cycle HI/LO write on completion.
module md_seq #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hi_we,
  output logic [31:0] hi_wdata,
  output logic        lo_we,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  state_t      state, state_d;
  logic [2:0]  cnt;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic        accept, is_div, new_signed, capture;
  logic [63:0] cap_data;

  // md_op = {div, divu, mult, multu}; div > divu > mult > multu on multi-hot input
  assign accept     = (state == IDLE) && op_valid && (md_op != 4'b0000) && !flush;
  assign is_div     = md_op[3] | md_op[2];
  assign new_signed = md_op[3] | (~md_op[2] & md_op[1]);
  assign capture    = (state_d == DONE) && (state != DONE);
  assign cap_data   = (state == MUL) ? mul_result : div_result;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = is_div ? DIV : MUL;
      MUL: begin
        if (flush)            state_d = IDLE;
        else if (cnt == 3'd0) state_d = DONE;
      end
      DIV: begin
        if (flush)          state_d = IDLE;
        else if (div_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallreq    = 1'b0;
    busy        = (state != IDLE);
    mul_signed  = 1'b0;
    mul_ina     = 32'd0;
    mul_inb     = 32'd0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_annul   = 1'b0;
    div_opdata1 = 32'd0;
    div_opdata2 = 32'd0;
    case (state)
      IDLE: stallreq = accept;
      MUL: begin
        stallreq   = !flush;
        mul_signed = op_signed;
        mul_ina    = op_a;
        mul_inb    = op_b;
      end
      DIV: begin
        stallreq    = !flush;
        div_signed  = op_signed;
        div_opdata1 = op_a;
        div_opdata2 = op_b;
        div_start   = !div_ready && !flush;
        div_annul   = flush;
      end
      default: ;
    endcase
    // the divider shares rst, so no annul is needed during reset
    if (rst) begin
      stallreq  = 1'b0;
      div_start = 1'b0;
      div_annul = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      hi_we     <= 1'b0;
      lo_we     <= 1'b0;
      hi_wdata  <= 32'd0;
      lo_wdata  <= 32'd0;
    end else begin
      if (accept) begin
        op_a      <= src1;
        op_b      <= src2;
        op_signed <= new_signed;
        cnt       <= is_div ? 3'd0 : CNT_INIT;
      end else if ((state == MUL) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      hi_we    <= capture;
      lo_we    <= capture;
      hi_wdata <= capture ? cap_data[63:32] : 32'd0;
      lo_wdata <= capture ? cap_data[31:0]  : 32'd0;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq with behavioural multiplier and 33-cycle divider models.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  md_op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        stallreq, busy, mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int div_cnt = 0;

  md_seq #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .md_op(md_op),
    .src1(src1), .src2(src2), .flush(flush),
    .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_result(div_result), .div_ready(div_ready),
    .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  // multiplier: low 64 bits of the extended product give the signed or unsigned result
  logic [63:0] ext_a, ext_b;
  always_comb begin
    ext_a = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
    ext_b = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    mul_result = ext_a * ext_b;
  end

  // divider: ready after 33 cycles of div_start
  logic signed [31:0] sd1, sd2;
  always_comb begin
    sd1 = div_opdata1;
    sd2 = div_opdata2;
    div_ready = (div_cnt >= 33);
    if (div_opdata2 == 32'd0)
      div_result = 64'd0;
    else if (div_signed)
      div_result = {32'(sd1 % sd2), 32'(sd1 / sd2)};
    else
      div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
  end

  always @(posedge clk) begin
    if (rst || !div_start) div_cnt <= 0;
    else                   div_cnt <= div_cnt + 1;
    if (hi_we) we_count <= we_count + 1;
  end

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; md_op = 4'b0010; src1 = 32'd5; src2 = 32'd9; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stallreq, busy, hi_we, lo_we, div_start, div_annul, mul_signed, div_signed} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000000",
               {stallreq, busy, hi_we, lo_we, div_start, div_annul, mul_signed, div_signed});
    end
    checks++;
    if ({hi_wdata, lo_wdata, mul_ina, mul_inb, div_opdata1, div_opdata2} !== 192'd0) begin
      errors++;
      $display("FAIL reset_data got hi=%h lo=%h ina=%h d1=%h expected 0",
               hi_wdata, lo_wdata, mul_ina, div_opdata1);
    end
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0; md_op = 4'b0000;
  endtask

  task automatic test_mult();
    int we0;
    @(negedge clk);
    we0 = we_count;
    op_valid = 1'b1; md_op = 4'b0010; src1 = 32'hFFFFFFFD; src2 = 32'h00000005;
    #1;
    checks++;
    if (stallreq !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mult_accept got stall=%b busy=%b expected 1 0", stallreq, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (stallreq !== 1'b1 || busy !== 1'b1 || mul_signed !== 1'b1 ||
        mul_ina !== 32'hFFFFFFFD || mul_inb !== 32'h00000005) begin
      errors++;
      $display("FAIL mult_mul1 got stall=%b busy=%b sgn=%b a=%h b=%h expected 1 1 1 fffffffd 00000005",
               stallreq, busy, mul_signed, mul_ina, mul_inb);
    end
    @(negedge clk); #1;
    checks++;
    if (stallreq !== 1'b1 || hi_we !== 1'b0) begin
      errors++; $display("FAIL mult_mul2 got stall=%b hi_we=%b expected 1 0", stallreq, hi_we);
    end
    @(negedge clk); #1;
    checks++;
    if (hi_we !== 1'b1 || lo_we !== 1'b1 || stallreq !== 1'b0 ||
        hi_wdata !== 32'hFFFFFFFF || lo_wdata !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_done got we=%b%b stall=%b hi=%h lo=%h expected 11 0 ffffffff fffffff1",
               hi_we, lo_we, stallreq, hi_wdata, lo_wdata);
    end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'b0000;
    #1;
    checks++;
    if (busy !== 1'b0 || hi_we !== 1'b0 || mul_ina !== 32'd0 || (we_count - we0) !== 1) begin
      errors++;
      $display("FAIL mult_idle got busy=%b hi_we=%b ina=%h writes=%0d expected 0 0 0 1",
               busy, hi_we, mul_ina, we_count - we0);
    end
  endtask

  task automatic test_multu();
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'b0001; src1 = 32'hFFFFFFFF; src2 = 32'h00000002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (mul_signed !== 1'b0 || stallreq !== 1'b1) begin
        errors++; $display("FAIL multu_mul%0d got sgn=%b stall=%b expected 0 1", i, mul_signed, stallreq);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (hi_we !== 1'b1 || hi_wdata !== 32'h00000001 || lo_wdata !== 32'hFFFFFFFE || mul_signed !== 1'b0) begin
      errors++;
      $display("FAIL multu_done got we=%b hi=%h lo=%h sgn=%b expected 1 00000001 fffffffe 0",
               hi_we, hi_wdata, lo_wdata, mul_signed);
    end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'b0000;
  endtask

  task automatic test_div();
    int n;
    bit done;
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'b1000; src1 = 32'hFFFFFFF9; src2 = 32'h00000002;
    #1;
    checks++;
    if (stallreq !== 1'b1) begin
      errors++; $display("FAIL div_accept got stall=%b expected 1", stallreq);
    end
    n = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk); #1;
      if (hi_we === 1'b1) done = 1;
      else begin
        n++;
        checks++;
        if (stallreq !== 1'b1 || div_signed !== 1'b1 || div_start !== !div_ready ||
            div_opdata1 !== 32'hFFFFFFF9 || div_opdata2 !== 32'h00000002) begin
          errors++;
          $display("FAIL div_run%0d got stall=%b sgn=%b start=%b ready=%b d1=%h expected 1 1 !ready fffffff9",
                   n, stallreq, div_signed, div_start, div_ready, div_opdata1);
        end
      end
    end
    checks++;
    if (!done || n !== 34) begin
      errors++; $display("FAIL div_latency got done=%0d cycles=%0d expected 1 34", done, n);
    end
    checks++;
    if (lo_wdata !== 32'hFFFFFFFD || hi_wdata !== 32'hFFFFFFFF || lo_we !== 1'b1 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL div_done got hi=%h lo=%h lo_we=%b stall=%b expected ffffffff fffffffd 1 0",
               hi_wdata, lo_wdata, lo_we, stallreq);
    end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'b0000;
  endtask

  task automatic test_divu_flush();
    int we0;
    @(negedge clk);
    we0 = we_count;
    op_valid = 1'b1; md_op = 4'b0100; src1 = 32'd100; src2 = 32'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (div_start !== 1'b1 || div_annul !== 1'b0 || div_signed !== 1'b0) begin
        errors++;
        $display("FAIL divu_run%0d got start=%b annul=%b sgn=%b expected 1 0 0", i, div_start, div_annul, div_signed);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (div_annul !== 1'b1 || div_start !== 1'b0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL divu_flush got annul=%b start=%b stall=%b expected 1 0 0", div_annul, div_start, stallreq);
    end
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; md_op = 4'b0000;
    #1;
    checks++;
    if (busy !== 1'b0 || div_annul !== 1'b0 || stallreq !== 1'b0 || div_opdata1 !== 32'd0) begin
      errors++;
      $display("FAIL divu_after got busy=%b annul=%b stall=%b d1=%h expected 0 0 0 0",
               busy, div_annul, stallreq, div_opdata1);
    end
    repeat (40) @(negedge clk);
    checks++;
    if ((we_count - we0) !== 0) begin
      errors++; $display("FAIL divu_nowrite got writes=%0d expected 0", we_count - we0);
    end
  endtask

  task automatic test_reset_mid_mul();
    int we0;
    @(negedge clk);
    we0 = we_count;
    op_valid = 1'b1; md_op = 4'b0010; src1 = 32'd7; src2 = 32'd6;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL rst_stall got %b expected 0", stallreq);
    end
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0; md_op = 4'b0000;
    #1;
    checks++;
    if ({stallreq, busy, hi_we, lo_we, mul_signed, div_annul} !== 6'd0 ||
        {mul_ina, mul_inb, hi_wdata, lo_wdata} !== 128'd0) begin
      errors++;
      $display("FAIL rst_outputs got ctrl=%b ina=%h hi=%h lo=%h expected 0",
               {stallreq, busy, hi_we, lo_we, mul_signed, div_annul}, mul_ina, hi_wdata, lo_wdata);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ((we_count - we0) !== 0) begin
      errors++; $display("FAIL rst_nowrite got writes=%0d expected 0", we_count - we0);
    end
    op_valid = 1'b1; md_op = 4'b0010; src1 = 32'd7; src2 = 32'd6;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (hi_we !== 1'b1 || hi_wdata !== 32'd0 || lo_wdata !== 32'h0000002A) begin
      errors++;
      $display("FAIL rst_fresh got we=%b hi=%h lo=%h expected 1 00000000 0000002a", hi_we, hi_wdata, lo_wdata);
    end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int we0, n;
    bit done;
    @(negedge clk);
    we0 = we_count;
    op_valid = 1'b1; md_op = 4'b0010; src1 = 32'd3; src2 = 32'd4;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (hi_we !== 1'b1 || lo_wdata !== 32'd12 || stallreq !== 1'b0) begin
      errors++; $display("FAIL b2b_mult got we=%b lo=%h stall=%b expected 1 0000000c 0", hi_we, lo_wdata, stallreq);
    end
    @(negedge clk);
    md_op = 4'b1000; src1 = 32'd20; src2 = 32'd3;
    #1;
    checks++;
    if (stallreq !== 1'b1 || hi_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got stall=%b we=%b busy=%b expected 1 0 0", stallreq, hi_we, busy);
    end
    n = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk); #1;
      if (hi_we === 1'b1) done = 1;
      else n++;
    end
    checks++;
    if (!done || n !== 34 || lo_wdata !== 32'd6 || hi_wdata !== 32'd2) begin
      errors++;
      $display("FAIL b2b_div got done=%0d cycles=%0d hi=%h lo=%h expected 1 34 00000002 00000006",
               done, n, hi_wdata, lo_wdata);
    end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ((we_count - we0) !== 2) begin
      errors++; $display("FAIL b2b_writes got %0d expected 2", we_count - we0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
